// File: rtl/cla_sub_8bit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_sub_8bit_pipe
// Purpose  : Two-stage pipelined subtractor (A - B) using borrow lookahead per
//            half-word, with valid/ready handshake on both sides.
//            Optional macro CLA_SUB_SAT_EN: unsigned saturation to zero on borrow.
// Revision : 1.0 - initial release
// ============================================================================
module cla_sub_8bit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   Diff
);

    localparam int c_HALF = WIDTH / 2;

    // Flattened lookahead: borrow into bit i is the OR of every generate below
    // i that survives the propagate chain up to i, plus the incoming borrow
    // surviving the full chain. No term depends on a previously computed borrow.
    function automatic logic [c_HALF:0] f_borrow_chain(
        input logic [c_HALF-1:0] g,
        input logic [c_HALF-1:0] p,
        input logic              bin
    );
        logic [c_HALF:0] b;
        logic            term;
        b    = '0;
        b[0] = bin;
        for (int i = 1; i <= c_HALF; i++) begin
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & p[k];
                end
                b[i] = b[i] | term;
            end
            term = bin;
            for (int k = 0; k < i; k++) begin
                term = term & p[k];
            end
            b[i] = b[i] | term;
        end
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_out_valid;
    logic w_s2_free;
    logic w_accept;

    assign w_s2_free = ~r_out_valid | out_ready;
    assign in_ready  = ~r_s1_valid | w_s2_free;
    assign w_accept  = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Stage 1: low half
    // ------------------------------------------------------------------
    logic [c_HALF-1:0] w_g_lo;
    logic [c_HALF-1:0] w_p_lo;
    logic [c_HALF:0]   w_b_lo;
    logic [c_HALF-1:0] w_d_lo;

    assign w_g_lo = ~A[c_HALF-1:0] & B[c_HALF-1:0];
    assign w_p_lo = ~(A[c_HALF-1:0] ^ B[c_HALF-1:0]);
    assign w_b_lo = f_borrow_chain(w_g_lo, w_p_lo, 1'b0);
    assign w_d_lo = A[c_HALF-1:0] ^ B[c_HALF-1:0] ^ w_b_lo[c_HALF-1:0];

    logic [c_HALF-1:0] r_s1_diff_lo;
    logic              r_s1_bout_lo;
    logic [c_HALF-1:0] r_s1_a_hi;
    logic [c_HALF-1:0] r_s1_b_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_diff_lo <= '0;
            r_s1_bout_lo <= 1'b0;
            r_s1_a_hi    <= '0;
            r_s1_b_hi    <= '0;
        end else if (w_accept) begin
            r_s1_valid   <= 1'b1;
            r_s1_diff_lo <= w_d_lo;
            r_s1_bout_lo <= w_b_lo[c_HALF];
            r_s1_a_hi    <= A[WIDTH-1:c_HALF];
            r_s1_b_hi    <= B[WIDTH-1:c_HALF];
        end else if (w_s2_free) begin
            r_s1_valid   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: high half, borrow-in from the registered low half
    // ------------------------------------------------------------------
    logic [c_HALF-1:0] w_g_hi;
    logic [c_HALF-1:0] w_p_hi;
    logic [c_HALF:0]   w_b_hi;
    logic [c_HALF-1:0] w_d_hi;
    logic [WIDTH:0]    w_diff_nxt;

    assign w_g_hi = ~r_s1_a_hi & r_s1_b_hi;
    assign w_p_hi = ~(r_s1_a_hi ^ r_s1_b_hi);
    assign w_b_hi = f_borrow_chain(w_g_hi, w_p_hi, r_s1_bout_lo);
    assign w_d_hi = r_s1_a_hi ^ r_s1_b_hi ^ w_b_hi[c_HALF-1:0];

`ifdef CLA_SUB_SAT_EN
    assign w_diff_nxt = w_b_hi[c_HALF] ? {1'b1, {WIDTH{1'b0}}}
                                       : {1'b0, w_d_hi, r_s1_diff_lo};
`else
    assign w_diff_nxt = {w_b_hi[c_HALF], w_d_hi, r_s1_diff_lo};
`endif

    logic [WIDTH:0] r_diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_diff      <= '0;
        end else if (w_s2_free) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_diff <= w_diff_nxt;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign Diff      = r_diff;

endmodule
`default_nettype wire

// File: tb/tb_cla_sub_8bit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_sub_8bit_pipe
// Purpose  : Scoreboard bench for cla_sub_8bit_pipe: directed cases, stall,
//            mid-stream reset and a random valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_sub_8bit_pipe;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   Diff;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH:0] sb_q[$];

    cla_sub_8bit_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [WIDTH:0] f_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int d;
        int lo;
        logic borrow;
        d      = int'(a) - int'(b);
        borrow = (d < 0);
        lo     = (d + 256) % 256;
`ifdef CLA_SUB_SAT_EN
        if (borrow) lo = 0;
`endif
        return {borrow, 8'(lo)};
    endfunction

    task automatic t_check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, i.e. the values the next rising edge will see.
    logic           prev_stall = 1'b0;
    logic [WIDTH:0] prev_diff  = '0;

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                t_check("stall_valid_hold", {31'd0, out_valid}, 32'd1);
                t_check("stall_diff_hold", {23'd0, Diff}, {23'd0, prev_diff});
            end
            if (in_valid && in_ready) sb_q.push_back(f_model(A, B));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    t_check("unexpected_output", {31'd0, out_valid}, 32'd0);
                end else begin
                    t_check("scoreboard_diff", {23'd0, Diff}, {23'd0, sb_q.pop_front()});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_diff  = Diff;
        end
    end

    task automatic t_single(input logic [7:0] a, input logic [7:0] b,
                            input logic [8:0] exp, input string name);
        @(posedge clk); #1;
        in_valid = 1'b1; A = a; B = b; out_ready = 1'b1;
        @(negedge clk);
        t_check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        t_check({name, "_early_valid"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        t_check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        t_check({name, "_diff"}, {23'd0, Diff}, {23'd0, exp});
        @(negedge clk);
        t_check({name, "_one_cycle"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int acc;
        int cyc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        t_check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        t_check("reset_diff", {23'd0, Diff}, 32'd0);
        t_check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed values, including borrow crossing the half boundary
        t_single(8'd200, 8'd55, 9'h091, "c8_37");
`ifdef CLA_SUB_SAT_EN
        t_single(8'd55, 8'd200, 9'h100, "37_c8");
        t_single(8'h00, 8'h01, 9'h100, "00_01");
`else
        t_single(8'd55, 8'd200, 9'h16F, "37_c8");
        t_single(8'h00, 8'h01, 9'h1FF, "00_01");
`endif
        t_single(8'h10, 8'h01, 9'h00F, "10_01");
        t_single(8'h00, 8'h00, 9'h000, "00_00");

        // Backpressure: four pairs, downstream blocked for cycles 0-5
        acc = 0;
        for (cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc >= 6);
            in_valid  = (acc < 4);
            A = 8'(acc + 1);
            B = 8'd1;
            @(negedge clk);
            if (cyc == 2) begin
                t_check("bp_accepts_before_stall", acc, 32'd2);
                t_check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            end
            if (cyc >= 3 && cyc <= 5) begin
                t_check("bp_diff_stalled", {23'd0, Diff}, 32'd0);
            end
            if (in_valid && in_ready) acc++;
        end
        t_check("bp_drained", sb_q.size(), 32'd0);

        // Reset with both stages occupied
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; A = 8'd9; B = 8'd3;
        @(posedge clk); #1;
        A = 8'd7; B = 8'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        t_check("mid_full_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        t_check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        t_check("mid_rst_diff", {23'd0, Diff}, 32'd0);
        t_check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        t_check("mid_rst_no_stale", {31'd0, out_valid}, 32'd0);

        // Random stream
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 40000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            A         = 8'($urandom_range(0, 255));
            B         = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            cyc++;
        end
        t_check("random_accept_count", acc, 32'd10000);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while ((sb_q.size() != 0 || out_valid) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        t_check("random_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
